// File: rtl/seq_detect_param_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_detect_param_pkg
// Purpose : Shared definitions for the seq_detect family: default pattern,
//           parameter-range checks and the per-cycle action encoding used by
//           the detector core.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seq_detect_param_pkg;

  // Default pattern: MSB is the first bit received.
  localparam logic [3:0] SEQ_PAT_1011 = 4'b1011;

  localparam int c_PAT_W_MIN = 2;
  localparam int c_PAT_W_MAX = 16;

  // Parameter-range checks shared by every seq_detect block.
  function automatic bit pat_w_ok(input int w);
    return (w >= c_PAT_W_MIN) && (w <= c_PAT_W_MAX);
  endfunction

  function automatic bit cnt_w_ok(input int w);
    return (w >= 1);
  endfunction

  // What the detector does with its history in a given cycle.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,  // en=0: everything holds
    ACT_LOAD  = 2'd1,  // pat_we=1: new pattern, history discarded
    ACT_SHIFT = 2'd2,  // consume a bit, no match
    ACT_MATCH = 2'd3   // consume a bit that completes the pattern
  } act_t;

endpackage : seq_detect_param_pkg
`default_nettype wire

// File: rtl/seq_detect_param_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : W-bit saturating event counter with synchronous clear. The clear
//           wins over a simultaneous increment. sat is registered and is high
//           exactly while cnt is all-ones.
// Ports   : clk  - clock (rising edge)
//           rst  - asynchronous active-high reset
//           inc  - count one event
//           clr  - synchronous clear of cnt and sat
//           cnt  - current count
//           sat  - cnt is at its maximum
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic [W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // sat is derived from the next count so it changes on the same edge as cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= &w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module  : seq_detect_param
// Purpose : Parametrised serial pattern detector with registered Mealy match
//           pulse, runtime-loadable pattern, overlap/non-overlap mode, input
//           qualification and a saturating match counter.
// Ports   : clk       - clock (rising edge)
//           rst       - asynchronous active-high reset
//           en        - qualifies in; a bit is consumed only when en=1
//           in        - serial data bit
//           pat_we    - load pat_in as the active pattern (wins over en)
//           pat_in    - new pattern, MSB is the first bit received
//           cnt_clr   - synchronous clear of match_cnt / cnt_sat
//           op        - one-cycle match pulse
//           match_cnt - saturating match count
//           cnt_sat   - match_cnt is all-ones
// Revision: 1.0 - initial release
// ============================================================================
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(SEQ_PAT_1011),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             pat_we,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             op,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W     = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PAT_W - 1);

  generate
    if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W out of range 2..16");
    end
    if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W must be at least 1");
    end
  endgenerate

  // History holds the PAT_W-1 most recent consumed bits, newest in the LSB;
  // r_fill counts how many of them are valid (the detector's "state").
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pat;
  logic              r_op;

  logic [PAT_W-2:0]  w_hist_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [PAT_W-1:0]  w_pat_nxt;
  logic [PAT_W-1:0]  w_cand;
  logic              w_match;
  act_t              w_act;

  assign w_cand  = {r_hist, in};
  assign w_match = en && !pat_we && (r_fill == c_FILL_MAX) && (w_cand == r_pat);

  always_comb begin
    w_act = ACT_HOLD;
    if (pat_we) begin
      w_act = ACT_LOAD;
    end else if (en) begin
      w_act = w_match ? ACT_MATCH : ACT_SHIFT;
    end
  end

  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_pat_nxt  = r_pat;
    case (w_act)
      ACT_LOAD: begin
        w_pat_nxt  = pat_in;
        w_hist_nxt = '0;
        w_fill_nxt = '0;
      end
      ACT_SHIFT: begin
        w_hist_nxt = w_cand[PAT_W-2:0];
        if (r_fill != c_FILL_MAX) begin
          w_fill_nxt = r_fill + 1'b1;
        end
      end
      ACT_MATCH: begin
        // Overlap keeps the tail of the match as the start of the next one;
        // non-overlap restarts from an empty history.
        if (OVERLAP) begin
          w_hist_nxt = w_cand[PAT_W-2:0];
        end else begin
          w_hist_nxt = '0;
          w_fill_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= PAT_RST;
      r_op   <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_pat  <= w_pat_nxt;
      r_op   <= w_match;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_match),
    .clr (cnt_clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign op = r_op;

endmodule : seq_detect_param
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detect_param
// Purpose : Self-checking bench for seq_detect_param. Three instances share
//           the stimulus: A (defaults, overlap), B (non-overlap) and
//           C (CNT_W=2, overlap). Each is compared every cycle against a
//           stream-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, in, pat_we, cnt_clr;
  logic [3:0] pat_in;

  logic       op_a, op_b, op_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in(in), .pat_we(pat_we), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .op(op_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in(in), .pat_we(pat_we), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .op(op_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in(in), .pat_we(pat_we), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .op(op_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  // ---------------- reference model ----------------
  // Each instance keeps the list of bits consumed since the last history
  // clear; a match is "the last four consumed bits spell the pattern".
  int m_seq [3][256];
  int m_len [3];
  int m_pat [3];
  int m_cnt [3];
  int m_op  [3];
  int m_ov  [3] = '{1, 0, 1};
  int m_max [3] = '{255, 255, 3};

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_len[i] = 0; m_pat[i] = 11; m_cnt[i] = 0; m_op[i] = 0;
    end
  endfunction

  function automatic void model_step(int e, int b, int we, int pin, int clr);
    for (int i = 0; i < 3; i++) begin
      m_op[i] = 0;
      if (we != 0) begin
        m_pat[i] = pin;
        m_len[i] = 0;
      end else if (e != 0) begin
        m_seq[i][m_len[i] % 256] = b;
        m_len[i]++;
        if (m_len[i] >= 4) begin
          int hit = 1;
          for (int k = 0; k < 4; k++) begin
            // Oldest of the last four bits must equal the pattern MSB.
            if (m_seq[i][(m_len[i] - 4 + k) % 256] != ((m_pat[i] >> (3 - k)) & 1)) hit = 0;
          end
          if (hit != 0) begin
            m_op[i] = 1;
            if (m_ov[i] == 0) m_len[i] = 0;
          end
        end
      end
      if (clr != 0) m_cnt[i] = 0;
      else if (m_op[i] != 0 && m_cnt[i] < m_max[i]) m_cnt[i]++;
    end
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.op",  int'(op_a),  m_op[0]);
    chk("a.cnt", int'(cnt_a), m_cnt[0]);
    chk("a.sat", int'(sat_a), int'(m_cnt[0] == m_max[0]));
    chk("b.op",  int'(op_b),  m_op[1]);
    chk("b.cnt", int'(cnt_b), m_cnt[1]);
    chk("b.sat", int'(sat_b), int'(m_cnt[1] == m_max[1]));
    chk("c.op",  int'(op_c),  m_op[2]);
    chk("c.cnt", int'(cnt_c), m_cnt[2]);
    chk("c.sat", int'(sat_c), int'(m_cnt[2] == m_max[2]));
  endtask

  // Inputs are applied just after an edge, consumed at the next edge, and
  // outputs are sampled 1 ns after that edge.
  task automatic step(int e, int b, int we = 0, int pin = 0, int clr = 0);
    en = e[0]; in = b[0]; pat_we = we[0]; pat_in = pin[3:0]; cnt_clr = clr[0];
    @(posedge clk);
    model_step(e, b, we, pin, clr);
    #1;
    check_all();
  endtask

  task automatic reload(int pin);
    step(0, 0, 1, pin, 1);
  endtask

  initial begin
    int s1 [7] = '{1, 0, 1, 1, 0, 1, 1};
    rst = 1'b1; en = 0; in = 0; pat_we = 0; pat_in = 0; cnt_clr = 0;
    model_reset();
    #12;
    check_all();          // reset state
    rst = 1'b0;

    // Stream 1011011: A pulses twice, B once, C twice (saturating at 3).
    for (int i = 0; i < 7; i++) step(1, s1[i]);
    chk("t1.a.cnt", int'(cnt_a), 2);
    chk("t1.b.cnt", int'(cnt_b), 1);

    // Idle bits in the middle of a pattern are ignored.
    reload(11);
    step(1, 1); step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    step(1, 1); step(1, 1);
    chk("t2.a.op", int'(op_a), 1);

    // Pattern load discards partial history; the in bit of the load cycle
    // is dropped even with en=1.
    step(1, 1); step(1, 0); step(1, 1);
    step(1, 1, 1, 6, 1);
    step(1, 0); step(1, 1); step(1, 1); step(1, 0);
    chk("t3.b.op", int'(op_b), 1);

    // Saturation on C with pattern 1111, then clear coinciding with a match.
    reload(15);
    for (int i = 0; i < 8; i++) step(1, 1);
    chk("t4.c.cnt", int'(cnt_c), 3);
    chk("t4.c.sat", int'(sat_c), 1);
    step(1, 1, 0, 0, 1);
    chk("t4.c.op.clr", int'(op_c), 1);
    chk("t4.c.cnt.clr", int'(cnt_c), 0);

    // Asynchronous reset mid-sequence.
    reload(11);
    step(1, 1); step(1, 0); step(1, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    step(1, 1);
    chk("t5.a.op", int'(op_a), 0);

    // Random traffic with occasional pattern loads and clears.
    for (int n = 0; n < 400; n++) begin
      int e   = ($urandom_range(0, 9) < 8) ? 1 : 0;
      int b   = int'($urandom_range(0, 1));
      int we  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      int pin = int'($urandom_range(0, 15));
      int clr = ($urandom_range(0, 29) == 0) ? 1 : 0;
      step(e, b, we, pin, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_detect_param
`default_nettype wire
